// File: rtl/itype_window.sv
// itype_window: builds the previous/current/next instruction window used by
// itype_detector from the in-order retired-instruction stream.
// Upstream handshake is ready/valid; downstream is strobe (out_valid_o) /
// accept (out_ready_i). flush_i drains the window so the last instruction is
// presented with nc_valid_o=0.
// Optional feature: define ITW_AUTO_DRAIN_EN to add an idle counter that
// triggers a drain after IDLE_TIMEOUT idle cycles with a current instruction.
module itype_window #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] iaddr_i,
  input  logic [XLEN-1:0] inst_data_i,
  input  logic            compressed_i,
  input  logic            exception_i,
  input  logic            interrupt_i,
  input  logic            eret_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            pc_valid_o,
  output logic            cc_valid_o,
  output logic            nc_valid_o,
  output logic [XLEN-1:0] pc_iaddr_o,
  output logic [XLEN-1:0] cc_iaddr_o,
  output logic [XLEN-1:0] nc_iaddr_o,
  output logic [XLEN-1:0] cc_inst_data_o,
  output logic            cc_compressed_o,
  output logic            cc_exception_o,
  output logic            cc_interrupt_o,
  output logic            cc_eret_o,
  output logic            draining_o
);

  if (IDLE_TIMEOUT < 1) begin : g_timeout_check
    $error("itype_window: IDLE_TIMEOUT must be >= 1");
  end

  typedef enum logic {
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] iaddr;
    logic [XLEN-1:0] data;
    logic            compressed;
    logic            exception;
    logic            interrupt;
    logic            eret;
  } slot_t;

  state_e          state;
  slot_t           c_q;
  slot_t           n_q;
  slot_t           in_slot;
  logic            p_valid_q;
  logic [XLEN-1:0] p_iaddr_q;
  logic            c_pend;

  logic            accept_in;
  logic            accept_out;
  logic            bubble;
  logic            go_drain;
  logic            timeout_hit;

  // Handshake and control decode from registered state
  always_comb begin
    in_slot     = {1'b1, iaddr_i, inst_data_i, compressed_i, exception_i,
                   interrupt_i, eret_i};
    out_valid_o = c_pend && (n_q.valid || (state == DRAIN));
    ready_o     = (state == RUN) && (!c_pend || out_ready_i);
    accept_in   = valid_i && ready_o;
    accept_out  = out_valid_o && out_ready_i;
    bubble      = (state == DRAIN) && (!c_pend || accept_out);
    go_drain    = (state == RUN) && (flush_i || timeout_hit);
  end

`ifdef ITW_AUTO_DRAIN_EN
  localparam int unsigned CW = $clog2(IDLE_TIMEOUT + 1);

  logic [CW-1:0] idle_cnt;
  logic          idle_cond;

  // Idle qualification: running, no input, and a current instruction waiting
  always_comb begin
    idle_cond   = (state == RUN) && !valid_i && c_q.valid;
    timeout_hit = idle_cond && (idle_cnt >= CW'(IDLE_TIMEOUT - 1));
  end

  // Saturating idle counter, cleared by input or by leaving RUN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt <= '0;
    end else if ((state != RUN) || go_drain || accept_in) begin
      idle_cnt <= '0;
    end else if (idle_cond && (idle_cnt != CW'(IDLE_TIMEOUT))) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Window shift register, pending flag and RUN/DRAIN state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= RUN;
      c_q       <= '0;
      n_q       <= '0;
      p_valid_q <= 1'b0;
      p_iaddr_q <= '0;
      c_pend    <= 1'b0;
    end else begin
      if (accept_in) begin
        p_valid_q <= c_q.valid;
        p_iaddr_q <= c_q.iaddr;
        c_q       <= n_q;
        n_q       <= in_slot;
        c_pend    <= n_q.valid;
      end else if (bubble) begin
        // Exit is decided on the post-shift window: once the bubble would
        // leave C and N empty the window is cleared and RUN resumes on the
        // same edge, so no empty DRAIN cycle is wasted.
        if (n_q.valid) begin
          p_valid_q <= c_q.valid;
          p_iaddr_q <= c_q.iaddr;
          c_q       <= n_q;
          n_q       <= '0;
          c_pend    <= 1'b1;
        end else begin
          p_valid_q <= 1'b0;
          p_iaddr_q <= '0;
          c_q       <= '0;
          n_q       <= '0;
          c_pend    <= 1'b0;
          state     <= RUN;
        end
      end else if (accept_out) begin
        c_pend <= 1'b0;
      end

      if (go_drain) begin
        state <= DRAIN;
      end
    end
  end

  // Registered slot contents drive the window outputs directly
  always_comb begin
    pc_valid_o      = p_valid_q;
    pc_iaddr_o      = p_iaddr_q;
    cc_valid_o      = c_q.valid;
    cc_iaddr_o      = c_q.iaddr;
    cc_inst_data_o  = c_q.data;
    cc_compressed_o = c_q.compressed;
    cc_exception_o  = c_q.exception;
    cc_interrupt_o  = c_q.interrupt;
    cc_eret_o       = c_q.eret;
    nc_valid_o      = n_q.valid;
    nc_iaddr_o      = n_q.iaddr;
    draining_o      = (state == DRAIN);
  end

endmodule

// File: tb/tb_itype_window.sv
// Self-checking bench for itype_window: directed scenarios plus randomized
// traffic, checked against a sequence-number based model of the window.
module tb_itype_window;

  localparam int unsigned XLEN   = 32;
  localparam int          IDLE_T = 4;

  logic            clk;
  logic            rst_n;
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] iaddr;
  logic [XLEN-1:0] idata;
  logic            comp, exc, intr, eret;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            pc_valid, cc_valid, nc_valid;
  logic [XLEN-1:0] pc_iaddr, cc_iaddr, nc_iaddr, cc_data;
  logic            cc_comp, cc_exc, cc_intr, cc_eret;
  logic            draining;

  int checks   = 0;
  int failures = 0;

  itype_window #(.XLEN(XLEN), .IDLE_TIMEOUT(IDLE_T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
    .iaddr_i(iaddr), .inst_data_i(idata), .compressed_i(comp),
    .exception_i(exc), .interrupt_i(intr), .eret_i(eret), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_valid_o(pc_valid), .cc_valid_o(cc_valid), .nc_valid_o(nc_valid),
    .pc_iaddr_o(pc_iaddr), .cc_iaddr_o(cc_iaddr), .nc_iaddr_o(nc_iaddr),
    .cc_inst_data_o(cc_data), .cc_compressed_o(cc_comp),
    .cc_exception_o(cc_exc), .cc_interrupt_o(cc_intr), .cc_eret_o(cc_eret),
    .draining_o(draining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Reference model: the window is the last three entries of the accepted
  // stream (bubbles appended while draining). Every instruction carries a
  // sequence number; the current slot is pending exactly when its number
  // equals the count of instructions classified so far.
  typedef struct {
    bit              valid;
    logic [XLEN-1:0] iaddr;
    logic [XLEN-1:0] data;
    bit              comp, exc, intr, eret;
    int              seq;
  } rec_t;

  rec_t w[$];
  int   n_cls;
  int   next_seq;
  bit   m_drain;
  int   m_idle;

  function automatic rec_t empty_rec();
    rec_t r;
    r.valid = 0; r.iaddr = '0; r.data = '0;
    r.comp = 0; r.exc = 0; r.intr = 0; r.eret = 0; r.seq = -1;
    return r;
  endfunction

  function automatic void model_reset();
    w.delete();
    for (int i = 0; i < 3; i++) w.push_back(empty_rec());
    n_cls = 0; next_seq = 0; m_drain = 0; m_idle = 0;
  endfunction

  function automatic bit m_pend();
    return w[1].valid && (w[1].seq == n_cls);
  endfunction

  function automatic bit m_out_valid();
    return m_pend() && (w[2].valid || m_drain);
  endfunction

  function automatic bit m_ready();
    return !m_drain && (!m_pend() || out_ready);
  endfunction

  function automatic void model_step();
    bit   pend    = m_pend();
    bit   acc_in  = valid && m_ready();
    bit   acc_out = m_out_valid() && out_ready;
    bit   was_run = !m_drain;
    bit   old_c   = w[1].valid;
    bit   to      = 0;
    rec_t r;
    if (was_run) begin
      if (acc_in) m_idle = 0;
      else if (!valid && old_c && m_idle < IDLE_T) m_idle++;
`ifdef ITW_AUTO_DRAIN_EN
      to = (m_idle >= IDLE_T);
`endif
    end
    if (acc_out) n_cls++;
    if (acc_in) begin
      r.valid = 1; r.iaddr = iaddr; r.data = idata;
      r.comp = comp; r.exc = exc; r.intr = intr; r.eret = eret;
      r.seq = next_seq++;
      w.push_back(r);
      void'(w.pop_front());
    end else if (m_drain && (!pend || acc_out)) begin
      w.push_back(empty_rec());
      void'(w.pop_front());
      if (!w[1].valid && !w[2].valid) begin
        for (int i = 0; i < 3; i++) w[i] = empty_rec();
        m_drain = 0;
      end
    end
    if (was_run && (flush || to)) m_drain = 1;
    if (m_drain || !was_run) m_idle = 0;
  endfunction

  function automatic logic [137:0] obs_vec();
    return {ready, out_valid, pc_valid, cc_valid, nc_valid, draining,
            cc_comp, cc_exc, cc_intr, cc_eret, pc_iaddr, cc_iaddr, nc_iaddr, cc_data};
  endfunction

  function automatic logic [137:0] exp_vec();
    return {m_ready(), m_out_valid(), w[0].valid, w[1].valid, w[2].valid, m_drain,
            w[1].comp, w[1].exc, w[1].intr, w[1].eret,
            w[0].iaddr, w[1].iaddr, w[2].iaddr, w[1].data};
  endfunction

  task automatic set_in(input bit v, input logic [XLEN-1:0] a, input bit f,
                        input bit ordy, input logic [3:0] attr);
    valid = v; iaddr = a; idata = {a[15:0], ~a[15:0]}; flush = f; out_ready = ordy;
    {comp, exc, intr, eret} = attr;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    set_in(0, '0, 0, 0, 4'b0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    set_in(0, '0, 0, 0, 4'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== {1'b1, 137'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got %h required %h", obs_vec(), {1'b1, 137'b0});
    end
    do_reset();
  endtask

  task automatic test_basic();
    logic [XLEN-1:0] addrs [3] = '{32'h1000, 32'h1004, 32'h1008};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, addrs[i], 0, 1, 4'b0);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL basic_cycle%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      tick();
      if (i == 1) begin
        checks++;
        if ({cc_iaddr, nc_iaddr, out_valid, pc_valid} !== {32'h1000, 32'h1004, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL basic_after2: got cc=%h nc=%h ov=%b pv=%b required cc=1000 nc=1004 ov=1 pv=0",
                   cc_iaddr, nc_iaddr, out_valid, pc_valid);
        end
      end
    end
    checks++;
    if ({pc_iaddr, cc_iaddr, nc_iaddr} !== {32'h1000, 32'h1004, 32'h1008}) begin
      failures++;
      $display("FAIL basic_after3: got pc=%h cc=%h nc=%h required 1000 1004 1008",
               pc_iaddr, cc_iaddr, nc_iaddr);
    end
  endtask

  task automatic test_backpressure();
    logic [137:0] snap;
    int acc_5000 = 0, acc_5004 = 0;
    do_reset();
    set_in(1, 32'h5000, 0, 1, 4'b0); tick();
    set_in(1, 32'h5004, 0, 1, 4'b0); tick();
    set_in(1, 32'h5008, 0, 0, 4'b0);
    #1;
    snap = obs_vec();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ready !== 1'b0 || obs_vec() !== snap) begin
        failures++;
        $display("FAIL backpressure_hold%0d: got rdy=%b %h required rdy=0 %h", i, ready, obs_vec(), snap);
      end
      tick();
      #1;
    end
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid && out_ready && cc_iaddr == 32'h5000) acc_5000++;
      if (out_valid && out_ready && cc_iaddr == 32'h5004) acc_5004++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL backpressure_release%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      tick();
      if (i == 0) begin
        checks++;
        if ({pc_iaddr, cc_iaddr, nc_iaddr} !== {32'h5000, 32'h5004, 32'h5008}) begin
          failures++;
          $display("FAIL backpressure_shift: got pc=%h cc=%h nc=%h required 5000 5004 5008",
                   pc_iaddr, cc_iaddr, nc_iaddr);
        end
      end
      set_in(0, '0, 0, 1, 4'b0);
      #1;
    end
    checks++;
    if (acc_5000 != 1 || acc_5004 != 1) begin
      failures++;
      $display("FAIL backpressure_once: got %0d,%0d acceptances required 1,1", acc_5000, acc_5004);
    end
  endtask

  task automatic test_drain();
    do_reset();
    set_in(1, 32'h2000, 0, 1, 4'b0); tick();
    set_in(1, 32'h2004, 0, 1, 4'b0); tick();
    set_in(0, '0, 1, 0, 4'b0); tick();
    set_in(0, '0, 0, 1, 4'b0);
    #1;
    checks++;
    if ({out_valid, cc_iaddr, nc_iaddr, ready, draining} !== {1'b1, 32'h2000, 32'h2004, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL drain_n: got ov=%b cc=%h nc=%h rdy=%b dr=%b required 1 2000 2004 0 1",
               out_valid, cc_iaddr, nc_iaddr, ready, draining);
    end
    tick();
    #1;
    checks++;
    if ({out_valid, cc_iaddr, nc_valid, ready} !== {1'b1, 32'h2004, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL drain_n1: got ov=%b cc=%h nv=%b rdy=%b required 1 2004 0 0",
               out_valid, cc_iaddr, nc_valid, ready);
    end
    tick();
    #1;
    checks++;
    if ({pc_valid, cc_valid, nc_valid, draining, ready} !== 5'b00001) begin
      failures++;
      $display("FAIL drain_n2: got pv=%b cv=%b nv=%b dr=%b rdy=%b required 0 0 0 0 1",
               pc_valid, cc_valid, nc_valid, draining, ready);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL drain_model: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_flush_with_valid();
    bit seen = 0;
    do_reset();
    set_in(1, 32'h3000, 1, 1, 4'b0); tick();
    set_in(0, '0, 0, 1, 4'b0);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid && cc_iaddr == 32'h3000 && !nc_valid && draining) seen = 1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL flushvalid_cycle%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (!draining) break;
      tick();
    end
    checks++;
    if (!seen || draining) begin
      failures++;
      $display("FAIL flushvalid_present: got seen=%b draining=%b required seen=1 draining=0", seen, draining);
    end
  endtask

  task automatic test_attrs_and_async_reset();
    do_reset();
    set_in(1, 32'h4000, 0, 1, 4'b0000); tick();
    set_in(1, 32'h4002, 0, 1, 4'b1100); tick();
    set_in(1, 32'h4004, 0, 1, 4'b0000); tick();
    checks++;
    if ({cc_iaddr, cc_comp, cc_exc, cc_intr, cc_eret} !== {32'h4002, 4'b1100}) begin
      failures++;
      $display("FAIL attrs_cc: got cc=%h c=%b e=%b i=%b r=%b required 4002 1 1 0 0",
               cc_iaddr, cc_comp, cc_exc, cc_intr, cc_eret);
    end
    set_in(0, '0, 1, 0, 4'b0); tick();
    set_in(0, '0, 0, 0, 4'b0);
    checks++;
    if (draining !== 1'b1) begin
      failures++;
      $display("FAIL attrs_draining: got %b required 1", draining);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== {1'b1, 137'b0}) begin
      failures++;
      $display("FAIL async_reset: got %h required %h", obs_vec(), {1'b1, 137'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 9) < 6, {$urandom_range(0, 16'hffff), 16'h0} | ($urandom & 32'hfffe),
             $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 7, 4'($urandom));
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

`ifdef ITW_AUTO_DRAIN_EN
  task automatic test_auto_drain();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      set_in(1, 32'h6000, 0, 1, 4'b0); tick();
      set_in(1, 32'h6004, 0, 1, 4'b0); tick();
      set_in(0, '0, 0, 1, 4'b0);
      if (pass == 1) begin
        for (int i = 0; i < 3; i++) tick();
        set_in(1, 32'h6008, 0, 1, 4'b0); tick();
        set_in(0, '0, 0, 1, 4'b0);
      end
      for (int i = 1; i <= IDLE_T; i++) begin
        tick();
        #1;
        checks++;
        if (draining !== (i == IDLE_T)) begin
          failures++;
          $display("FAIL autodrain_p%0d_c%0d: got %b required %b", pass, i, draining, (i == IDLE_T));
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL autodrain_model_p%0d_c%0d: got %h required %h", pass, i, obs_vec(), exp_vec());
        end
      end
      for (int i = 0; i < 6; i++) tick();
    end
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    set_in(0, '0, 0, 0, 4'b0);
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_drain();
    test_flush_with_valid();
    test_attrs_and_async_reset();
`ifdef ITW_AUTO_DRAIN_EN
    test_auto_drain();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
